// File: rtl/grain_injector.sv
// grain_injector: adds one grain per rate tick to the sandpile cell at (drop_x, drop_y) by read-modify-write; cells reaching 4 are queued for toppling.
// Latency: tick -> write grant is 5 cycles with immediate grants; a topple entry is visible the cycle after PUSH.
// Backpressure: holds mem_req until mem_gnt, stalls in PUSH while the queue is full; surplus ticks collapse into one pending drop.
// Build option INJ_STATS_EN: when defined, drop_count/reject_count are live wrapping counters; otherwise both are tied to 0.
module grain_injector #(
    parameter int ROWS       = 32,
    parameter int COLS       = 32,
    parameter int CELL_W     = 3,
    parameter int FIFO_DEPTH = 4,
    localparam int ADDR_W    = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [8:0]        drop_x,
    input  logic [8:0]        drop_y,
    input  logic [8:0]        resolution,
    input  logic [15:0]       rate_div,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [CELL_W-1:0] mem_wdata,
    input  logic [CELL_W-1:0] mem_rdata,
    input  logic              mem_gnt,
    output logic              topple_valid,
    output logic [ADDR_W-1:0] topple_addr,
    input  logic              topple_ready,
    output logic              busy,
    output logic [15:0]       drop_count,
    output logic [15:0]       reject_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE, ST_SAMPLE, ST_RD_REQ, ST_RD_WAIT, ST_WR_REQ, ST_PUSH
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [15:0]        r_rate_cnt;
    logic               r_pending;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [CELL_W-1:0]  r_wdata;
    logic [ADDR_W-1:0]  r_fifo [FIFO_DEPTH];
    logic [PTR_W:0]     r_wr_ptr;
    logic [PTR_W:0]     r_rd_ptr;

    logic               w_tick;
    logic               w_take;
    logic               w_accept;
    logic               w_reject;
    logic               w_rd_cap;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_coord_ok;
    logic [ADDR_W-1:0]  w_sample_addr;
    logic [CELL_W-1:0]  w_nv;

    assign w_tick        = enable && (r_rate_cnt == 16'd0);
    assign w_coord_ok    = (drop_x < resolution) && (drop_y < resolution) &&
                           (int'(drop_x) < COLS) && (int'(drop_y) < ROWS);
    assign w_sample_addr = ADDR_W'(int'(drop_y) * COLS + int'(drop_x));
    assign w_nv          = (&mem_rdata) ? mem_rdata : mem_rdata + CELL_W'(1);

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_pop   = !w_empty && topple_ready;

    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign topple_valid = !w_empty;
    assign topple_addr  = w_empty ? '0 : r_fifo[r_rd_ptr[PTR_W-1:0]];
    assign busy         = (r_state != ST_IDLE);

    // Rate divider: only advances while enabled, so a paused game keeps its phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rate_cnt <= 16'd0;
        end else if (enable) begin
            r_rate_cnt <= (r_rate_cnt == 16'd0) ? rate_div : r_rate_cnt - 16'd1;
        end
    end

    // One-deep drop request; a rejected sample re-arms it so the next coordinate is tried.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= w_tick || w_reject || (r_pending && !w_take);
        end
    end

    // Drop sequencer: state register plus registered memory request strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mem_req <= (w_state_nxt == ST_RD_REQ) || (w_state_nxt == ST_WR_REQ);
            r_mem_we  <= (w_state_nxt == ST_WR_REQ);
        end
    end

    // Drop sequencer: next state and per-state strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_rd_cap    = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pending) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (w_coord_ok) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RD_REQ;
                end else begin
                    w_reject    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                if (mem_gnt) w_state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                w_rd_cap    = 1'b1;
                w_state_nxt = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                if (mem_gnt) w_state_nxt = (int'(r_wdata) >= 4) ? ST_PUSH : ST_IDLE;
            end
            ST_PUSH: begin
                if (!w_full || w_pop) begin
                    w_push      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Address and incremented height are held here so they stay stable across grant stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            if (w_accept) r_addr  <= w_sample_addr;
            if (w_rd_cap) r_wdata <= w_nv;
        end
    end

    // Topple queue pointers; the extra MSB separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Topple queue storage; on a full push+pop the slot written is the one being read out.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr[PTR_W-1:0]] <= r_addr;
    end

`ifdef INJ_STATS_EN
    logic [15:0] r_drop_cnt;
    logic [15:0] r_reject_cnt;

    // Statistics: completed writes and out-of-range samples, both wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt   <= 16'd0;
            r_reject_cnt <= 16'd0;
        end else begin
            if ((r_state == ST_WR_REQ) && mem_gnt) r_drop_cnt <= r_drop_cnt + 16'd1;
            if (w_reject) r_reject_cnt <= r_reject_cnt + 16'd1;
        end
    end

    assign drop_count   = r_drop_cnt;
    assign reject_count = r_reject_cnt;
`else
    assign drop_count   = 16'd0;
    assign reject_count = 16'd0;
`endif

endmodule

// File: tb/tb_grain_injector.sv
// tb_grain_injector: scoreboard bench for grain_injector with a behavioural cell memory and arbiter.
// Reads are answered from the bench memory, which pushes the expected write and topple entries.
// A negedge monitor pops and compares on every write grant and topple handshake.
module tb_grain_injector;
    localparam int ROWS = 32;
    localparam int COLS = 32;
    localparam int CELL_W = 3;
    localparam int AW = 10;
`ifdef INJ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, enable;
    logic [8:0] drop_x, drop_y, resolution;
    logic [15:0] rate_div;
    logic mem_req, mem_we, mem_gnt;
    logic [AW-1:0] mem_addr, topple_addr;
    logic [CELL_W-1:0] mem_wdata, mem_rdata;
    logic topple_valid, topple_ready, busy;
    logic [15:0] drop_count, reject_count;

    grain_injector #(.ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .drop_x(drop_x), .drop_y(drop_y),
        .resolution(resolution), .rate_div(rate_div), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_gnt(mem_gnt),
        .topple_valid(topple_valid), .topple_addr(topple_addr), .topple_ready(topple_ready),
        .busy(busy), .drop_count(drop_count), .reject_count(reject_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int model_mem [ROWS*COLS];
    int exp_addr;
    int q_wr_addr[$], q_wr_dat[$], q_wr_old[$], q_top[$];
    int n_wr = 0, n_top = 0;
    int gnt_mode = 0;
    bit rd_hs = 1'b0;
    int rd_val = 0;
    bit chk_iv = 1'b0;
    int last_wr = -1;
    int cur_rate = 0;
    bit prev_stall = 1'b0;
    logic [AW-1:0] st_addr;
    logic st_we;
    logic [CELL_W-1:0] st_wdata;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= (1 << CELL_W) - 1) ? v : v + 1;
    endfunction

    function automatic logic [31:0] exp_stat(input int v);
        return STATS ? (v & 32'hFFFF) : 32'd0;
    endfunction

    // Memory/arbiter: returns read data the cycle after a read grant, grants per gnt_mode.
    initial begin
        mem_gnt = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rd_hs) begin
                mem_rdata = rd_val[CELL_W-1:0];
                rd_hs = 1'b0;
            end
            case (gnt_mode)
                0: mem_gnt = 1'b1;
                1: mem_gnt = 1'($urandom_range(0, 1));
                2: mem_gnt = 1'b0;
                default: mem_gnt = !mem_we;
            endcase
        end
    end

    // Monitor: request stability, read address, write scoreboard, topple scoreboard.
    always @(negedge clk) begin
        int a, old, nv;
        if (rst_n) begin
            if (prev_stall) begin
                chk("req_held", mem_req, 1);
                chk("req_stable_addr", mem_addr, st_addr);
                chk("req_stable_we", mem_we, st_we);
                if (st_we) chk("req_stable_wdata", mem_wdata, st_wdata);
            end
            prev_stall = mem_req && !mem_gnt;
            st_addr = mem_addr;
            st_we = mem_we;
            st_wdata = mem_wdata;
            if (mem_req && mem_gnt) begin
                if (!mem_we) begin
                    chk("rd_addr", mem_addr, exp_addr);
                    a = int'(mem_addr);
                    old = model_mem[a];
                    nv = sat_inc(old);
                    rd_val = old;
                    rd_hs = 1'b1;
                    q_wr_addr.push_back(a);
                    q_wr_dat.push_back(nv);
                    q_wr_old.push_back(old);
                    model_mem[a] = nv;
                    if (nv >= 4) q_top.push_back(a);
                end else begin
                    if (q_wr_addr.size() == 0) begin
                        chk("wr_unexpected", 1, 0);
                    end else begin
                        chk("wr_addr", mem_addr, q_wr_addr.pop_front());
                        chk("wr_data", mem_wdata, q_wr_dat.pop_front());
                        void'(q_wr_old.pop_front());
                    end
                    n_wr++;
                    if (chk_iv && last_wr >= 0) chk("wr_interval", cyc - last_wr, cur_rate + 1);
                    last_wr = cyc;
                end
            end
            if (topple_valid && topple_ready) begin
                if (q_top.size() == 0) chk("topple_unexpected", 1, 0);
                else chk("topple_addr", topple_addr, q_top.pop_front());
                n_top++;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_xy(input int x, input int y);
        drop_x = 9'(x);
        drop_y = 9'(y);
        exp_addr = y * COLS + x;
    endtask

    // Writes lost to reset never reach memory, so the bench memory is rolled back.
    task automatic flush();
        while (q_wr_addr.size() > 0) begin
            model_mem[q_wr_addr.pop_back()] = q_wr_old.pop_back();
            void'(q_wr_dat.pop_back());
        end
        q_top.delete();
        rd_hs = 1'b0;
        n_wr = 0;
        n_top = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        flush();
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic drain(input int maxc);
        int quiet = 0;
        int k = 0;
        while (quiet < 4 && k < maxc) begin
            step(1);
            k++;
            if (!busy && !topple_valid && q_wr_addr.size() == 0 && q_top.size() == 0) quiet++;
            else quiet = 0;
        end
        chk("drain_done", (quiet >= 4), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int res, x, y, lim, k;
        rst_n = 1'b0;
        enable = 1'b0;
        resolution = 9'd32;
        rate_div = 16'd0;
        topple_ready = 1'b1;
        foreach (model_mem[i]) model_mem[i] = 0;
        set_xy(0, 0);
        step(3);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_topple_valid", topple_valid, 0);
        chk("rst_topple_addr", topple_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_reject_count", reject_count, 0);
        rst_n = 1'b1;
        step(1);

        // Fixed-rate drops at (3,2): ticks on enabled cycles 1,11,21,31,41.
        model_mem[67] = 1;
        set_xy(3, 2);
        rate_div = 16'd9;
        cur_rate = 9;
        last_wr = -1;
        chk_iv = 1'b1;
        enable = 1'b1;
        step(50);
        enable = 1'b0;
        drain(200);
        chk_iv = 1'b0;
        chk("t1_drops", n_wr, 5);
        chk("t1_topples", n_top, 3);
        chk("t1_drop_count", drop_count, exp_stat(5));

        // Out-of-range sample is retried every two cycles until the coordinate becomes valid.
        do_reset();
        resolution = 9'd16;
        set_xy(20, 2);
        rate_div = 16'd100;
        enable = 1'b1;
        step(3);
        chk("t2_no_req", mem_req, 0);
        chk("t2_reject1", reject_count, exp_stat(1));
        step(2);
        chk("t2_reject2", reject_count, exp_stat(2));
        enable = 1'b0;
        set_xy(5, 2);
        drain(100);
        chk("t2_drops", n_wr, 1);
        chk("t2_drop_count", drop_count, exp_stat(1));
        chk("t2_reject_final", reject_count, exp_stat(2));
        resolution = 9'd32;

        // Read grant withheld: request stays stable, ticks during the stall give one more drop.
        do_reset();
        set_xy(7, 9);
        model_mem[295] = 0;
        gnt_mode = 2;
        rate_div = 16'd3;
        enable = 1'b1;
        step(1);
        enable = 1'b0;
        step(4);
        chk("t3_req", mem_req, 1);
        chk("t3_addr", mem_addr, 295);
        chk("t3_busy", busy, 1);
        enable = 1'b1;
        step(10);
        enable = 1'b0;
        step(2);
        chk("t3_req_still", mem_req, 1);
        gnt_mode = 0;
        drain(100);
        chk("t3_drops", n_wr, 2);
        chk("t3_drop_count", drop_count, exp_stat(2));

        // Topple queue fills with ready low; fifth push waits, then drains in order.
        do_reset();
        set_xy(1, 1);
        model_mem[33] = 6;
        topple_ready = 1'b0;
        rate_div = 16'd7;
        enable = 1'b1;
        step(35);
        enable = 1'b0;
        step(15);
        chk("t4_stall_busy", busy, 1);
        chk("t4_valid", topple_valid, 1);
        chk("t4_head", topple_addr, 33);
        chk("t4_drops", n_wr, 5);
        topple_ready = 1'b1;
        drain(100);
        chk("t4_topples", n_top, 5);

        // Reset during a stalled write: everything clears at once.
        do_reset();
        set_xy(4, 0);
        model_mem[4] = 5;
        topple_ready = 1'b0;
        rate_div = 16'd0;
        enable = 1'b1;
        step(1);
        enable = 1'b0;
        step(12);
        gnt_mode = 3;
        enable = 1'b1;
        step(1);
        enable = 1'b0;
        k = 0;
        while (!(mem_req && mem_we) && k < 20) begin
            step(1);
            k++;
        end
        chk("t5_in_write", (mem_req && mem_we), 1);
        chk("t5_fifo_loaded", topple_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_req_cleared", mem_req, 0);
        chk("t5_we_cleared", mem_we, 0);
        chk("t5_fifo_empty", topple_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_drop_count", drop_count, 0);
        step(1);
        flush();
        rst_n = 1'b1;
        gnt_mode = 0;
        topple_ready = 1'b1;
        step(2);

        // Randomised rounds: coordinates, window, rate, grants and topple backpressure.
        for (int r = 0; r < 8; r++) begin
            res = $urandom_range(8, 40);
            x = $urandom_range(0, 40);
            y = $urandom_range(0, 40);
            resolution = 9'(res);
            set_xy(x, y);
            if (x < res && y < res && x < COLS && y < ROWS) model_mem[y * COLS + x] = $urandom_range(0, 7);
            rate_div = 16'($urandom_range(0, 12));
            gnt_mode = 1;
            enable = 1'b1;
            for (int c = 0; c < 80; c++) begin
                topple_ready = 1'($urandom_range(0, 1));
                step(1);
            end
            enable = 1'b0;
            topple_ready = 1'b1;
            if (!(x < res && y < res && x < COLS && y < ROWS)) begin
                lim = (res < COLS) ? res : COLS;
                set_xy($urandom_range(0, lim - 1), $urandom_range(0, lim - 1));
            end
            drain(600);
            chk("rand_drop_count", drop_count, exp_stat(n_wr));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
